// File: rtl/mmu_pkg.sv
// Shared types for the MMU command sequencer: command codes,
// sequencer states and the 4-lane operand packing.
package mmu_pkg;

    typedef enum logic [4:0] {
        CMD_RESET            = 5'd0,
        CMD_TRIGGER          = 5'd1,
        CMD_TRIGGER_LAST     = 5'd2,
        CMD_SET_MUL_VAL      = 5'd3,
        CMD_SET_ADD_VAL      = 5'd4,
        CMD_SET_PE_VAL       = 5'd5,
        CMD_SET_CONV_MODE    = 5'd6,
        CMD_SET_FIX_MAC_MODE = 5'd7,
        CMD_FORWARD          = 5'd8,
        CMD_TRIGGER_BN       = 5'd17
    } mmu_cmd_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_FLUSH,
        S_WAIT,
        S_DRAIN
    } seq_state_e;

    localparam int MMU_LANE_W = 32;

    // Lane 3 carries row/column 1, lane 0 carries row/column 4.
    typedef logic [3:0][MMU_LANE_W-1:0] mmu_lanes_t;

endpackage

// File: rtl/mmu_res_drain.sv
// Captures the four MMU result columns and returns them as a
// 4-beat valid/ready stream.
module mmu_res_drain
    import mmu_pkg::*;
#(
    parameter int W = 32
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           capture,
    input  logic           active,
    input  logic [4*W-1:0] rdata_1_in,
    input  logic [4*W-1:0] rdata_2_in,
    input  logic [4*W-1:0] rdata_3_in,
    input  logic [4*W-1:0] rdata_4_in,
    input  logic           res_ready,
    output logic           res_valid,
    output logic [4*W-1:0] res_data,
    output logic           res_last,
    output logic           done
);

    logic [3:0][4*W-1:0] res_buf;
    logic [1:0]          beat;

    assign res_valid = active;
    assign res_last  = active && (beat == 2'd3);
    assign res_data  = active ? res_buf[beat] : '0;
    assign done      = active && res_ready && (beat == 2'd3);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            res_buf <= '0;
            beat    <= '0;
        end else if (capture) begin
            res_buf <= {rdata_4_in, rdata_3_in, rdata_2_in, rdata_1_in};
            beat    <= '0;
        end else if (active && res_ready) begin
            // Wraps back to 0 after the last beat.
            beat <= beat + 2'd1;
        end
    end

endmodule

// File: rtl/mmu_cmd_seq.sv
// Command initiator and operand feeder for the 4x4 systolic MMU:
// RESET, K operand beats, FORWARD flush, idle wait, result drain.
module mmu_cmd_seq
    import mmu_pkg::*;
#(
    parameter int ACLEN      = 8,
    parameter int DATA_WIDTH = 32,
    parameter int KLEN       = 16,
    parameter int FLUSH_CYC  = 7
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    job_valid,
    output logic                    job_ready,
    input  logic [KLEN-1:0]         job_k,
    input  logic                    op_valid,
    output logic                    op_ready,
    input  logic [DATA_WIDTH*4-1:0] op_data,
    input  logic [DATA_WIDTH*4-1:0] op_weight,
    output logic                    mmu_cmd_valid,
    output logic [ACLEN:0]          mmu_cmd,
    output logic [DATA_WIDTH*4-1:0] param_1_out,
    output logic [DATA_WIDTH*4-1:0] param_2_out,
    output logic [DATA_WIDTH*4-1:0] param_3_out,
    output logic [DATA_WIDTH*4-1:0] param_4_out,
    output logic [DATA_WIDTH-1:0]   data_1_out,
    output logic [DATA_WIDTH-1:0]   data_2_out,
    output logic [DATA_WIDTH-1:0]   data_3_out,
    output logic [DATA_WIDTH-1:0]   data_4_out,
    output logic [DATA_WIDTH-1:0]   weight_1_out,
    output logic [DATA_WIDTH-1:0]   weight_2_out,
    output logic [DATA_WIDTH-1:0]   weight_3_out,
    output logic [DATA_WIDTH-1:0]   weight_4_out,
    input  logic                    mmu_busy,
    input  logic [DATA_WIDTH*4-1:0] rdata_1_in,
    input  logic [DATA_WIDTH*4-1:0] rdata_2_in,
    input  logic [DATA_WIDTH*4-1:0] rdata_3_in,
    input  logic [DATA_WIDTH*4-1:0] rdata_4_in,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [DATA_WIDTH*4-1:0] res_data,
    output logic                    res_last,
    output logic                    seq_busy
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = ACLEN + 1;
    localparam int FW = $clog2(FLUSH_CYC + 1);

    seq_state_e     state, state_d;
    logic [KLEN-1:0] rem, rem_d;
    logic [FW-1:0]  fcnt, fcnt_d;
    logic           cmd_valid_d;
    logic [CW-1:0]  cmd_d;
    logic [4*W-1:0] data_q, data_d;
    logic [4*W-1:0] weight_q, weight_d;
    logic           fire;
    logic           capture;
    logic           drain_done;

    // Held low during reset so every output reads 0 while rst_i is high.
    assign job_ready = (state == S_IDLE) && !rst_i;
    assign op_ready  = (state == S_FEED);
    assign seq_busy  = (state != S_IDLE);
    assign fire      = op_valid && op_ready;
    assign capture   = (state == S_WAIT) && !mmu_busy;

    assign param_1_out = '0;
    assign param_2_out = '0;
    assign param_3_out = '0;
    assign param_4_out = '0;

    assign data_1_out   = data_q[4*W-1:3*W];
    assign data_2_out   = data_q[3*W-1:2*W];
    assign data_3_out   = data_q[2*W-1:W];
    assign data_4_out   = data_q[W-1:0];
    assign weight_1_out = weight_q[4*W-1:3*W];
    assign weight_2_out = weight_q[3*W-1:2*W];
    assign weight_3_out = weight_q[2*W-1:W];
    assign weight_4_out = weight_q[W-1:0];

    always_comb begin
        state_d     = state;
        rem_d       = rem;
        fcnt_d      = fcnt;
        cmd_valid_d = 1'b0;
        cmd_d       = mmu_cmd;
        data_d      = data_q;
        weight_d    = weight_q;
        unique case (state)
            S_IDLE: begin
                if (job_valid) begin
                    rem_d   = job_k;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                cmd_valid_d = 1'b1;
                cmd_d       = CW'(CMD_RESET);
                data_d      = '0;
                weight_d    = '0;
                if (rem != '0) begin
                    state_d = S_FEED;
                end else begin
                    state_d = S_FLUSH;
                    fcnt_d  = FW'(FLUSH_CYC);
                end
            end
            S_FEED: begin
                if (fire) begin
                    cmd_valid_d = 1'b1;
                    data_d      = op_data;
                    weight_d    = op_weight;
                    rem_d       = rem - KLEN'(1);
                    if (rem == KLEN'(1)) begin
                        cmd_d   = CW'(CMD_TRIGGER_LAST);
                        state_d = S_FLUSH;
                        fcnt_d  = FW'(FLUSH_CYC);
                    end else begin
                        cmd_d = CW'(CMD_TRIGGER);
                    end
                end
            end
            S_FLUSH: begin
                cmd_valid_d = 1'b1;
                cmd_d       = CW'(CMD_FORWARD);
                data_d      = '0;
                weight_d    = '0;
                fcnt_d      = fcnt - FW'(1);
                if (fcnt == FW'(1)) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!mmu_busy) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drain_done) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= S_IDLE;
            rem           <= '0;
            fcnt          <= '0;
            mmu_cmd_valid <= 1'b0;
            mmu_cmd       <= '0;
            data_q        <= '0;
            weight_q      <= '0;
        end else begin
            state         <= state_d;
            rem           <= rem_d;
            fcnt          <= fcnt_d;
            mmu_cmd_valid <= cmd_valid_d;
            mmu_cmd       <= cmd_d;
            data_q        <= data_d;
            weight_q      <= weight_d;
        end
    end

    mmu_res_drain #(
        .W (W)
    ) u_drain (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .capture    (capture),
        .active     (state == S_DRAIN),
        .rdata_1_in (rdata_1_in),
        .rdata_2_in (rdata_2_in),
        .rdata_3_in (rdata_3_in),
        .rdata_4_in (rdata_4_in),
        .res_ready  (res_ready),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .res_last   (res_last),
        .done       (drain_done)
    );

endmodule

// File: doc/mmu_cmd_seq.md
Name: mmu_cmd_seq

Overview:
- Command initiator and operand feeder for the 4x4 systolic MMU. Accepts one GEMM tile job of K accumulation steps.
- Per job: issues RESET, streams K operand beats as TRIGGER/TRIGGER_LAST, issues FORWARD flush commands, and waits for MMU idle.
- Then captures the four 128-bit result columns and returns them as a 4-beat valid/ready stream.
- Sits between the operand buffers/DMA and the MMU command port.

Parameters:
- ACLEN, 8, MMU command width is ACLEN+1.
- DATA_WIDTH, 32, element width.
- KLEN, 16, width of the job_k step counter.
- FLUSH_CYC, 7, number of FORWARD commands after TRIGGER_LAST (3 skew + 3 propagate + 1).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- job_valid  in  1  job request.
- job_ready  out  1  high only in IDLE.
- job_k  in  KLEN  number of operand beats; 0 is legal.
- op_valid  in  1  operand beat available.
- op_ready  out  1  combinational, high only in FEED.
- op_data  in  DATA_WIDTH*4  row operands; [4W-1:3W] is row 1 … [W-1:0] is row 4.
- op_weight  in  DATA_WIDTH*4  column operands, same packing as op_data.
- mmu_cmd_valid  out  1  registered.
- mmu_cmd  out  ACLEN+1  registered.
- param_1_out..param_4_out  out  DATA_WIDTH*4 each  driven 0.
- data_1_out..data_4_out  out  DATA_WIDTH each  registered.
- weight_1_out..weight_4_out  out  DATA_WIDTH each  registered.
- mmu_busy  in  1  MMU busy.
- rdata_1_in..rdata_4_in  in  DATA_WIDTH*4 each  MMU result columns.
- res_valid  out  1  result beat valid.
- res_ready  in  1  result beat accepted.
- res_data  out  DATA_WIDTH*4  result column.
- res_last  out  1  high on beat 3.
- seq_busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async): state=IDLE; every output 0; counters and result buffer cleared. Reset mid-job aborts immediately. MMU contents are not touched; the next job's RESET clears them.
- FSM states: IDLE, CLEAR, FEED, FLUSH, WAIT, DRAIN.
- IDLE:
  - job_ready=1.
  - On job_valid: latch job_k into rem, go to CLEAR.
- CLEAR:
  - 1 cycle; registers mmu_cmd_valid=1, mmu_cmd=RESET(0), data/weight=0.
  - Next state is FEED if rem!=0, else FLUSH.
- FEED:
  - op_ready=1. Each op_valid&&op_ready handshake registers mmu_cmd_valid=1 with data_n/weight_n from op_data/op_weight.
  - mmu_cmd=TRIGGER(1) normally; TRIGGER_LAST(2) when rem==1. rem decrements.
  - Cycles with op_valid=0 register mmu_cmd_valid=0 (bubble); MMU skew registers hold.
  - After the TRIGGER_LAST beat, go to FLUSH with flush counter = FLUSH_CYC.
- FLUSH:
  - FLUSH_CYC consecutive cycles of mmu_cmd_valid=1, mmu_cmd=FORWARD(8), data/weight=0.
  - Then go to WAIT.
- WAIT:
  - mmu_cmd_valid=0. Minimum 1 cycle.
  - First cycle with mmu_busy==0: capture rdata_1_in..rdata_4_in into buf[0..3], go to DRAIN, beat=0.
- DRAIN:
  - res_valid=1, res_data=buf[beat], res_last=(beat==3).
  - beat increments on res_valid&&res_ready. Hold data stable while res_ready=0.
  - On the beat-3 handshake go to IDLE; job_ready rises the next cycle.
- Latency: MMU command appears 1 cycle after its source handshake/state entry. Best-case job (K beats, no bubbles) is 1+K+FLUSH_CYC+1 cycles to first res_valid.
- job_valid outside IDLE is ignored and not queued.
- op_valid outside FEED is ignored; no beat is consumed.
- No timeout; WAIT holds indefinitely while mmu_busy=1.
- rem is KLEN bits; max job_k=2^KLEN-1, no wrap.

Decomposition:
- Shared package mmu_pkg:
  - command codes RESET=0, TRIGGER=1, TRIGGER_LAST=2, SET_MUL_VAL=3, SET_ADD_VAL=4, SET_PE_VAL=5, SET_CONV_MODE=6, SET_FIX_MAC_MODE=7, FORWARD=8, TRIGGER_BN=17;
  - FSM state enum typedef;
  - packed 4-lane operand typedef.
- One natural sub-module: mmu_res_drain, holding the 4x128 capture buffer, beat counter and res handshake.

Test Plan:
- job_k=1, op_data={1,2,3,4}, op_weight={5,6,7,8}, mmu_busy low → commands RESET, TRIGGER_LAST, 7×FORWARD, in that order on consecutive cycles. res beats 0..3 equal rdata_1..4; res_last on beat 3 only.
- job_k=4 with op_valid low on cycles 2 and 3 → exactly 3 TRIGGER + 1 TRIGGER_LAST, with mmu_cmd_valid=0 on the bubble cycles. data_1_out matches op_data[127:96] of each beat in order.
- job_k=0 → RESET then 7×FORWARD, no TRIGGER, op_ready never high, 4 result beats returned.
- mmu_busy held high 20 cycles after flush → no res_valid until 1 cycle after mmu_busy falls. Captured values are those present on the fall cycle.
- res_ready low 5 cycles on beat 2 → res_data/res_last stable; job_valid during DRAIN is ignored until IDLE.
- rst_i asserted mid-FEED (rem=3) → all outputs 0 asynchronously; after release the next job begins with RESET and completes normally.
